// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - nibble-serial N-bit adder sequencer around one shared 4-bit ripple slice
// Optional subtract path and signed overflow flag: NIBBLE_SERIAL_SUB_EN

module adder_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic [3:0] o_c
);
    logic w_c0, w_c1, w_c2, w_c3;

    assign w_c0 = (i_a[0] & i_b[0]) | (i_cin & (i_a[0] ^ i_b[0]));
    assign w_c1 = (i_a[1] & i_b[1]) | (w_c0  & (i_a[1] ^ i_b[1]));
    assign w_c2 = (i_a[2] & i_b[2]) | (w_c1  & (i_a[2] ^ i_b[2]));
    assign w_c3 = (i_a[3] & i_b[3]) | (w_c2  & (i_a[3] ^ i_b[3]));

    assign o_sum = i_a ^ i_b ^ {w_c2, w_c1, w_c0, i_cin};
    assign o_c   = {w_c3, w_c2, w_c1, w_c0};
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [4*WORDS-1:0] a,
    input  logic [4*WORDS-1:0] b,
    input  logic               cin,
    output logic               busy,
    output logic               done,
    output logic [4*WORDS-1:0] s,
    output logic               cout
`ifdef NIBBLE_SERIAL_SUB_EN
    ,
    input  logic               sub,
    output logic               ovf
`endif
);
    localparam int W    = 4 * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_s;
    logic [IDXW-1:0]   r_idx;
    logic              r_carry;
    logic              r_cout;
    logic              w_accept;
    logic              w_last;
    logic              w_cin_eff;
    logic [3:0]        w_na;
    logic [3:0]        w_nb;
    logic [3:0]        w_nb_eff;
    logic [3:0]        w_sum;
    logic [3:0]        w_c;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_idx == IDXW'(WORDS - 1));

    always_comb begin
        w_na = '0;
        w_nb = '0;
        for (int n = 0; n < WORDS; n++) begin
            if (r_idx == IDXW'(n)) begin
                w_na = r_a[4*n +: 4];
                w_nb = r_b[4*n +: 4];
            end
        end
    end

`ifdef NIBBLE_SERIAL_SUB_EN
    logic r_sub;
    logic r_ovf;
    logic w_unused_c;

    // Subtraction is a + ~b + 1: invert B per nibble and force the initial carry.
    assign w_nb_eff   = r_sub ? ~w_nb : w_nb;
    assign w_cin_eff  = sub ? 1'b1 : cin;
    assign w_unused_c = ^w_c[1:0];
    assign ovf        = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_sub <= sub;
        end else if (r_state == S_RUN && w_last) begin
            r_ovf <= w_c[2] ^ w_c[3];
        end
    end
`else
    logic w_unused_c;

    assign w_nb_eff   = w_nb;
    assign w_cin_eff  = cin;
    assign w_unused_c = ^w_c[2:0];
`endif

    adder_4bit u_slice (
        .i_a   (w_na),
        .i_b   (w_nb_eff),
        .i_cin (r_carry),
        .o_sum (w_sum),
        .o_c   (w_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // s and cout are never cleared by a new start; nibbles are overwritten as they are computed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= w_cin_eff;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            for (int n = 0; n < WORDS; n++) begin
                if (r_idx == IDXW'(n)) begin
                    r_s[4*n +: 4] <= w_sum;
                end
            end
            r_carry <= w_c[3];
            r_idx   <= w_last ? '0 : r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_c[3];
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign s    = r_s;
    assign cout = r_cout;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - randomized self-checking bench for nibble_serial_adder_ctrl (WORDS=4)
module tb_nibble_serial_adder_ctrl;
    localparam int WORDS = 4;
    localparam int W     = 4 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
`ifdef NIBBLE_SERIAL_SUB_EN
        ,
        .sub   (sub),
        .ovf   (ovf)
`endif
    );

`ifndef NIBBLE_SERIAL_SUB_EN
    assign ovf = 1'b0;
`endif

    // Issues one start pulse, scrambles the inputs afterwards, and measures busy cycles and start-to-done latency.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc, input logic ts,
                          output logic [W-1:0] rs, output logic rc, output logic ro,
                          output int nbusy, output int lat);
        @(posedge clk); #1;
        start = 1'b1; a = ta; b = tbv; cin = tc; sub = ts;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        nbusy = 0;
        lat   = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) nbusy++;
            if (done) break;
        end
        rs = s; rc = cout; ro = ovf;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (s !== '0) begin n_fail++; $display("FAIL reset_s: got %h want 0000", s); end
        n_cmp++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", cout); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL idle_quiet: got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_basic();
        logic [W-1:0] rs; logic rc, ro; int nb, lat;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, rs, rc, ro, nb, lat);
        n_cmp++; if (nb !== WORDS) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want %0d", nb, WORDS); end
        n_cmp++; if (lat !== WORDS + 1) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, WORDS + 1); end
        n_cmp++; if (rs !== 16'h5555) begin n_fail++; $display("FAIL basic_s: got %h want 5555", rs); end
        n_cmp++; if (rc !== 1'b0) begin n_fail++; $display("FAIL basic_cout: got %b want 0", rc); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        n_cmp++; if (s !== 16'h5555 || cout !== 1'b0) begin n_fail++; $display("FAIL basic_hold: got %h/%b want 5555/0", s, cout); end
    endtask

    task automatic test_carry_chain();
        logic [W-1:0] rs; logic rc, ro; int nb, lat;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, nb, lat);
        n_cmp++; if (rs !== 16'h0000 || rc !== 1'b1) begin n_fail++; $display("FAIL chain_ffff: got %h/%b want 0000/1", rs, rc); end
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, rs, rc, ro, nb, lat);
        n_cmp++; if (rs !== 16'h0001 || rc !== 1'b0) begin n_fail++; $display("FAIL chain_cin: got %h/%b want 0001/0", rs, rc); end
    endtask

    task automatic test_start_while_busy();
        int ndone = 0;
        logic [W-1:0] s_at_done = '0;
        @(posedge clk); #1;
        start = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; start = 1'b1; a = 16'h1111; b = 16'h1111;
        @(posedge clk); #1; start = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (done) begin ndone++; s_at_done = s; end
        end
        n_cmp++; if (ndone !== 1) begin n_fail++; $display("FAIL busy_start_dones: got %0d want 1", ndone); end
        n_cmp++; if (s_at_done !== 16'h5555) begin n_fail++; $display("FAIL busy_start_s: got %h want 5555", s_at_done); end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] rs; logic rc, ro; int nb, lat;
        int ndone = 0;
        @(posedge clk); #1;
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: got busy=%b done=%b want 0 0", busy, done); end
        n_cmp++; if (s !== '0 || cout !== 1'b0) begin n_fail++; $display("FAIL midrst_data: got %h/%b want 0000/0", s, cout); end
        @(posedge clk); #1; rst_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        n_cmp++; if (ndone !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d want 0", ndone); end
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, rs, rc, ro, nb, lat);
        n_cmp++; if (rs !== 16'h1000 || rc !== 1'b0) begin n_fail++; $display("FAIL midrst_after: got %h/%b want 1000/0", rs, rc); end
    endtask

    task automatic test_back_to_back();
        int first = 0, second = 0;
        logic [W-1:0] s1 = '0, s2 = '0;
        logic c1 = 1'b0, c2 = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        a = 16'h8000; b = 16'h8000;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (done) begin
                if (first == 0) begin first = j; s1 = s; c1 = cout; end
                else if (second == 0) begin second = j; s2 = s; c2 = cout; end
            end
            if (j == 10) start = 1'b0;
        end
        n_cmp++; if (first !== WORDS + 1 || second !== 2 * (WORDS + 1)) begin n_fail++; $display("FAIL b2b_timing: got done at %0d,%0d want %0d,%0d", first, second, WORDS + 1, 2 * (WORDS + 1)); end
        n_cmp++; if (s1 !== 16'h5555 || c1 !== 1'b0) begin n_fail++; $display("FAIL b2b_first: got %h/%b want 5555/0", s1, c1); end
        n_cmp++; if (s2 !== 16'h0000 || c2 !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got %h/%b want 0000/1", s2, c2); end
    endtask

    task automatic test_random();
        logic [W-1:0] rs, ta, tbv; logic rc, ro, tc; int nb, lat;
        logic [W:0] expv;
        for (int i = 0; i < 24; i++) begin
            ta  = W'($urandom);
            tbv = (i % 4 == 0) ? ~ta : W'($urandom);
            tc  = 1'($urandom);
            expv = ta + tbv + tc;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            run_op(ta, tbv, tc, 1'b0, rs, rc, ro, nb, lat);
            n_cmp++; if ({rc, rs} !== expv) begin n_fail++; $display("FAIL rand_sum[%0d]: %h+%h+%b got %b/%h want %b/%h", i, ta, tbv, tc, rc, rs, expv[W], expv[W-1:0]); end
            n_cmp++; if (lat !== WORDS + 1) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, WORDS + 1); end
        end
    endtask

`ifdef NIBBLE_SERIAL_SUB_EN
    task automatic test_sub();
        logic [W-1:0] rs, ta, tbv; logic rc, ro, ts, tc; int nb, lat;
        logic [W:0] expv; logic expo;
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, rs, rc, ro, nb, lat);
        n_cmp++; if (rs !== 16'hFFFE || rc !== 1'b0 || ro !== 1'b0) begin n_fail++; $display("FAIL sub_5m7: got %h/%b/%b want fffe/0/0", rs, rc, ro); end
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, rs, rc, ro, nb, lat);
        n_cmp++; if (rs !== 16'h7FFF || rc !== 1'b1 || ro !== 1'b1) begin n_fail++; $display("FAIL sub_8000m1: got %h/%b/%b want 7fff/1/1", rs, rc, ro); end
        for (int i = 0; i < 16; i++) begin
            ta = W'($urandom); tbv = W'($urandom); ts = 1'($urandom); tc = 1'($urandom);
            expv = ts ? ({1'b0, ta} + {1'b0, ~tbv} + 1) : ({1'b0, ta} + {1'b0, tbv} + tc);
            expo = ts ? ((ta[W-1] != tbv[W-1]) && (expv[W-1] != ta[W-1]))
                      : ((ta[W-1] == tbv[W-1]) && (expv[W-1] != ta[W-1]));
            run_op(ta, tbv, tc, ts, rs, rc, ro, nb, lat);
            n_cmp++; if ({rc, rs} !== expv || ro !== expo) begin n_fail++; $display("FAIL sub_rand[%0d]: sub=%b got %b/%h/%b want %b/%h/%b", i, ts, rc, rs, ro, expv[W], expv[W-1:0], expo); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
`ifdef NIBBLE_SERIAL_SUB_EN
        test_sub();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that time-shares one 4-bit ripple adder slice (`adder_4bit`) to add N-bit operands, one nibble per clock, least-significant nibble first.
- Carry is held in a register between nibbles.
- Sits between a requester (start/done handshake) and the shared 4-bit datapath; replaces a full-width adder where area matters more than latency.

Parameters:
- WORDS, 4, number of nibbles per operand; operand width W = 4*WORDS; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when state is IDLE or DONE
- a  input  W  operand A, captured on accepted start
- b  input  W  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse; s and cout valid
- s  output  W  registered sum
- cout  output  1  registered final carry-out

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset: on rst_n low, immediately and regardless of state:
  - state=IDLE, nibble index=0, carry reg=0, operand regs=0
  - busy=0, done=0, s=0, cout=0
- Reset asserted mid-RUN aborts the operation. No done pulse is produced.
- Datapath: exactly one `adder_4bit` instance.
  - Inputs: nibble[idx] of the captured A and B, plus the carry register.
  - Carry-out of the nibble is bit c[3] of the slice.
  - No second adder; no full-width `+` operator.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at edge k → capture a, b; carry reg←cin; idx←0; go to RUN. start=0 → stay.
  - RUN, at each edge: s[4*idx+3:4*idx]←slice sum; carry reg←slice carry-out; idx←idx+1.
  - RUN, at the edge where idx=WORDS-1: also cout←slice carry-out; go to DONE.
  - DONE: done=1 for exactly this one cycle.
    - Next edge with start=1 → accept a new operation exactly as from IDLE (back-to-back).
    - Next edge with start=0 → go to IDLE.
- Latency: start sampled at edge k; nibbles processed at edges k+1..k+WORDS; done high during the cycle after edge k+WORDS.
  - Throughput: one result per WORDS+1 cycles with continuous start.
- busy: high from edge k+1 through edge k+WORDS, i.e. exactly in RUN; low in IDLE and DONE.
- start while busy: ignored, not queued.
- a, b, cin changes during RUN: no effect (operands are captured).
- s during RUN: updates nibble by nibble; only valid when done=1 and thereafter.
- s and cout hold their values in IDLE until the next accepted start.
  - On an accepted start, s and cout are not cleared; they are overwritten progressively.
- Arithmetic: {cout,s} = a + b + cin, modulo 2^(W+1).
- WORDS=1: RUN lasts one cycle; same rules apply.

Optional Feature:
- Macro: NIBBLE_SERIAL_SUB_EN.
- Defined:
  - Adds input `sub` (1 bit, captured on start) and output `ovf` (1 bit, reset 0, updated with cout).
  - sub=1: each B nibble is inverted before the slice; carry reg←1 at start (cin ignored); result s = a − b mod 2^W; cout=1 means no borrow.
  - ovf = signed two's-complement overflow of the W-bit operation: carry into MSB XOR carry out of MSB, taken from the last nibble.
  - sub=0: identical to the add path; ovf still computed.
- Undefined: no `sub` or `ovf` ports; add only.

Test Plan (WORDS=4):
- Basic add: a=0x1234, b=0x4321, cin=0, start pulse → busy high 4 cycles; done one cycle after the 4th RUN edge; s=0x5555, cout=0.
- Full carry chain: a=0xFFFF, b=0x0001, cin=0 → s=0x0000, cout=1. Also a=0, b=0, cin=1 → s=0x0001, cout=0.
- Start while busy: second start with a=0x1111 on RUN cycle 2 → ignored; first result s=0x5555 completes; no extra done.
- Reset mid-RUN: rst_n low on RUN cycle 2 → busy, done, s, cout read 0 immediately. After release and start with a=0x0F0F, b=0x00F1 → s=0x1000, cout=0.
- Back-to-back: start held high continuously → done every 5 cycles. Results 0x1234+0x4321=0x5555, then 0x8000+0x8000 → s=0x0000, cout=1.
- NIBBLE_SERIAL_SUB_EN, sub=1:
  - 0x0005−0x0007 → s=0xFFFE, cout=0, ovf=0
  - 0x8000−0x0001 → s=0x7FFF, cout=1, ovf=1
